// File: rtl/pe_wrapper_sdiv_16s_16s_16_seq.sv
// rtl/pe_wrapper_sdiv_16s_16s_16_seq.sv - sequential signed radix-2 restoring divider with valid/ready handshakes
module pe_wrapper_sdiv_16s_16s_16_seq #(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] quot,
  output logic [DIN1_WIDTH-1:0] rem
);

  localparam int N  = DIN0_WIDTH;
  localparam int M  = DIN1_WIDTH;
  // Partial remainder must hold a shifted value up to twice the largest divisor
  // magnitude, and the whole dividend when the divisor is zero.
  localparam int RW = ((N > M) ? N : M) + 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;    // dividend magnitude shifting out, quotient bits shifting in
  logic [M:0]    dvs;    // divisor magnitude, one extra bit so -2^(M-1) is exact
  logic [RW-1:0] r;      // partial remainder
  logic          qneg;
  logic          rneg;
  logic          dz;

  logic [N-1:0]  a_mag;
  logic [M:0]    b_ext;
  logic [M:0]    b_mag;
  logic [RW-1:0] r_sh;
  logic [RW-1:0] dvs_ext;
  logic [RW-1:0] r_sub;
  logic          ge;
  logic [N-1:0]  q_res;
  logic [M-1:0]  r_mag;
  logic [M-1:0]  r_res;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Operand magnitudes, one restoring step, and the signed result fix-up
  always_comb begin
    // An N-bit unsigned value holds 2^(N-1), so the most-negative dividend is exact
    a_mag   = din0[N-1] ? (~din0 + N'(1)) : din0;
    b_ext   = {din1[M-1], din1};
    b_mag   = din1[M-1] ? (~b_ext + (M + 1)'(1)) : b_ext;
    r_sh    = {r[RW-2:0], dvd[N-1]};
    dvs_ext = RW'(dvs);
    // A set top bit means the true shifted value exceeds any divisor
    ge      = r[RW-1] | (r_sh >= dvs_ext);
    r_sub   = r_sh - dvs_ext;
    q_res   = dz ? {N{1'b1}} : (qneg ? (~dvd + N'(1)) : dvd);
    r_mag   = r[M-1:0];
    r_res   = rneg ? (~r_mag + M'(1)) : r_mag;
  end

  // Control FSM and datapath registers: accept in IDLE, N steps plus fix-up in CALC, hold in DONE
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      r     <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      dz    <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dvd   <= a_mag;
            dvs   <= b_mag;
            r     <= '0;
            qneg  <= din0[N-1] ^ din1[M-1];
            rneg  <= din0[N-1];
            dz    <= (din1 == '0);
            cnt   <= CW'(N);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (cnt != '0) begin
            r   <= ge ? r_sub : r_sh;
            dvd <= {dvd[N-2:0], ge};
            cnt <= cnt - CW'(1);
          end else begin
            // Extra cycle after the last step applies signs, keeping latency fixed at N+1
            quot  <= q_res[DOUT_WIDTH-1:0];
            rem   <= r_res;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_wrapper_sdiv_16s_16s_16_seq.sv
// tb/tb_pe_wrapper_sdiv_16s_16s_16_seq.sv - directed and random checks of the sequential signed divider
module tb_pe_wrapper_sdiv_16s_16s_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] din0 = '0;
  logic [15:0] din1 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quot;
  logic [15:0] rem;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  pe_wrapper_sdiv_16s_16s_16_seq #(
    .ID(1), .DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // in_ready and out_valid must never be high together
  always @(negedge ap_clk) begin
    if (mon_en) check("rdy_vld_excl", {31'b0, in_ready & out_valid}, 32'd0);
  end

  task automatic ref_div(input int sa, input int sb, output logic [15:0] q, output logic [15:0] r);
    int qi, ri;
    if (sb == 0) begin
      qi = -1; ri = sa;
    end else if (sa == -32768 && sb == -1) begin
      qi = -32768; ri = 0;
    end else begin
      qi = sa / sb; ri = sa % sb;
    end
    q = 16'(qi);
    r = 16'(ri);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int w;
    w = 0;
    @(negedge ap_clk);
    while (!in_ready && w < 50) begin
      @(negedge ap_clk);
      w++;
    end
    if (w >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    din0 = 16'($urandom);
    din1 = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge ap_clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic handshake(input string tag);
    @(negedge ap_clk);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input int a, input int b, input logic [15:0] eq,
                        input logic [15:0] er);
    int lat, qi, ri;
    start_op(16'(a), 16'(b));
    wait_done(lat);
    check({tag, "_lat"}, lat, 32'd17);
    check({tag, "_quot"}, {16'b0, quot}, {16'b0, eq});
    check({tag, "_rem"}, {16'b0, rem}, {16'b0, er});
    if (b != 0 && !(a == -32768 && b == -1)) begin
      qi = int'($signed(quot));
      ri = int'($signed(rem));
      check({tag, "_inv"}, qi * b + ri, a);
      check({tag, "_remlt"}, {31'b0, ((ri < 0) ? -ri : ri) < ((b < 0) ? -b : b)}, 32'd1);
    end
    handshake(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] eq, er;
    int sa, sb;

    #1 ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_quot", {16'b0, quot}, 32'd0);
    check("rst_rem", {16'b0, rem}, 32'd0);
    ap_rst = 1'b0;
    mon_en = 1'b1;

    // Basic and sign combinations
    run_op("d100_7", 100, 7, 16'd14, 16'd2);
    run_op("dm100_7", -100, 7, 16'hFFF2, 16'hFFFE);
    run_op("d100_m7", 100, -7, 16'hFFF2, 16'd2);
    run_op("dm100_m7", -100, -7, 16'd14, 16'hFFFE);
    run_op("d0_5", 0, 5, 16'd0, 16'd0);

    // Edge cases
    run_op("ovf", -32768, -1, 16'h8000, 16'd0);
    run_op("dz5", 5, 0, 16'hFFFF, 16'd5);
    run_op("dzm5", -5, 0, 16'hFFFF, 16'hFFFB);
    run_op("min_1", -32768, 1, 16'h8000, 16'd0);
    run_op("min_m7", -32768, -7, 16'd4681, 16'hFFFF);

    // Backpressure with in_valid held high throughout
    @(negedge ap_clk);
    in_valid = 1'b1;
    din0 = 16'd77;
    din1 = 16'(-5);
    @(posedge ap_clk);
    #1;
    wait_done(lat);
    check("bp_lat", lat, 32'd17);
    check("bp_quot", {16'b0, quot}, 32'h0000FFF1);
    check("bp_rem", {16'b0, rem}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk);
      #1;
      check("bp_hold_vld", {31'b0, out_valid}, 32'd1);
      check("bp_hold_rdy", {31'b0, in_ready}, 32'd0);
      check("bp_hold_quot", {16'b0, quot}, 32'h0000FFF1);
      check("bp_hold_rem", {16'b0, rem}, 32'd2);
    end
    @(negedge ap_clk);
    din0 = 16'(-100);
    din1 = 16'(-7);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    check("bp_no_accept_hs", {31'b0, in_ready}, 32'd1);
    check("bp_hs_vld", {31'b0, out_valid}, 32'd0);
    @(posedge ap_clk);
    #1;
    check("bp_accept_next", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_done(lat);
    check("bp2_lat", lat, 32'd17);
    check("bp2_quot", {16'b0, quot}, 32'd14);
    check("bp2_rem", {16'b0, rem}, 32'h0000FFFE);
    handshake("bp2");

    // Asynchronous reset in the middle of the calculation
    start_op(16'd1000, 16'(-3));
    repeat (8) @(posedge ap_clk);
    #2;
    ap_rst = 1'b1;
    #1;
    check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_quot", {16'b0, quot}, 32'd0);
    check("mrst_rem", {16'b0, rem}, 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    run_op("post_rst", 1000, -3, 16'hFEB3, 16'd1);

    // Random signed pairs against the reference model
    for (int i = 0; i < 2000; i++) begin
      sa = int'($signed(16'($urandom)));
      case (i % 4)
        0: sb = int'($urandom_range(0, 8)) - 4;
        1: sb = int'($signed(16'($urandom_range(0, 255))));
        default: sb = int'($signed(16'($urandom)));
      endcase
      if (i == 7) sa = -32768;
      ref_div(sa, sb, eq, er);
      run_op("rnd", sa, sb, eq, er);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
